sobel_row_loader: RTL and testbench

//  Feeds the parallel row input of sobel_filter_scalable.

---
 rtl/sobel_row_loader.sv | 142 ++++++++++++++
 tb/tb_sobel_row_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_row_loader.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_row_loader
//  Purpose  : Serial-to-parallel row assembler for sobel_filter_scalable.
//             Pixels arrive on a valid/ready stream and are collected into a
//             fill buffer. Each completed row moves into a hold register that
//             drives arr_out, so row N+1 can fill while row N is presented.
//             A row cut short by pix_last is padded by repeating its final
//             pixel, and err_short_row pulses for one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module sobel_row_loader #(
  parameter int SIZE  = 100,
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PIX_W-1:0]            pix_in,
  input  logic                        pix_valid,
  input  logic                        pix_last,
  output logic                        pix_ready,
  output logic [SIZE-1:0][PIX_W-1:0]  arr_out,
  output logic                        row_valid,
  input  logic                        row_ack,
  output logic                        err_short_row,
  output logic [CNT_W-1:0]            row_count
);

  localparam int IDX_W = $clog2(SIZE);

  // ST_FULL holds a completed row in the fill buffer until the hold register frees up
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [SIZE-1:0][PIX_W-1:0]  fill_q, fill_d;
  logic [SIZE-1:0][PIX_W-1:0]  hold_q, hold_d;
  logic                        row_valid_q, row_valid_d;
  logic                        err_q, err_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic w_accept;
  logic w_at_end;
  logic w_complete;
  logic w_short;
  logic w_hold_free;

  // Handshake and row-boundary decode
  assign pix_ready   = (state_q == ST_FILL) & ~rst;
  assign w_accept    = pix_valid & pix_ready;
  assign w_at_end    = (idx_q == IDX_W'(SIZE - 1));
  assign w_complete  = w_accept & (w_at_end | pix_last);
  assign w_short     = w_accept & pix_last & ~w_at_end;
  assign w_hold_free = ~row_valid_q | row_ack;

  // Next-state logic: pixel capture, edge replication, and fill-to-hold handoff
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    hold_d      = hold_q;
    row_valid_d = row_valid_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    // An acked row is released unless a new one replaces it below
    if (row_valid_q && row_ack) begin
      row_valid_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (w_accept) begin
          // Write the current slot; on a short row also flood every later slot
          for (int j = 0; j < SIZE; j++) begin
            if ((idx_q == IDX_W'(j)) || (w_short && (idx_q < IDX_W'(j)))) begin
              fill_d[j] = pix_in;
            end
          end
          err_d = w_short;
          if (w_complete) begin
            if (w_hold_free) begin
              // Hand the just-finished row over with no extra cycle
              hold_d      = fill_d;
              row_valid_d = 1'b1;
              cnt_d       = cnt_q + CNT_W'(1);
              idx_d       = '0;
            end else begin
              state_d = ST_FULL;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (w_hold_free) begin
          hold_d      = fill_q;
          row_valid_d = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          idx_d       = '0;
          state_d     = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and output registers; reset discards any partial row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      fill_q      <= '0;
      hold_q      <= '0;
      row_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      hold_q      <= hold_d;
      row_valid_q <= row_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign arr_out       = hold_q;
  assign row_valid     = row_valid_q;
  assign err_short_row = err_q;
  assign row_count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_row_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_row_loader
//  Purpose  : Scoreboard bench for sobel_row_loader (SIZE=8, narrow counter
//             so row_count wrap is reached naturally).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sobel_row_loader;

  localparam int SIZE  = 8;
  localparam int PIX_W = 8;
  localparam int CNT_W = 4;

  typedef logic [SIZE-1:0][PIX_W-1:0] row_t;

  typedef struct {
    row_t             row;
    logic [CNT_W-1:0] cnt;
    longint           t;
    bit               free;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PIX_W-1:0] pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             pix_last = 1'b0;
  logic             pix_ready;
  row_t             arr_out;
  logic             row_valid;
  logic             row_ack = 1'b0;
  logic             err_short_row;
  logic [CNT_W-1:0] row_count;

  sobel_row_loader #(.SIZE(SIZE), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_in        (pix_in),
    .pix_valid     (pix_valid),
    .pix_last      (pix_last),
    .pix_ready     (pix_ready),
    .arr_out       (arr_out),
    .row_valid     (row_valid),
    .row_ack       (row_ack),
    .err_short_row (err_short_row),
    .row_count     (row_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  exp_t             exp_q[$];
  longint           err_q[$];
  row_t             cur_row = '0;
  int               cur_len = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  int               completed = 0;
  int               presented = 0;
  bit               in_reset = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Row assembly from the stream rules: SIZE pixels, or fewer ended by pix_last and padded
  task automatic model_accept(input logic [PIX_W-1:0] p, input bit last, input bit free, input longint t);
    exp_t e;
    cur_row[cur_len] = p;
    cur_len++;
    if (cur_len == SIZE || last) begin
      if (cur_len < SIZE) err_q.push_back(t);
      for (int j = cur_len; j < SIZE; j++) cur_row[j] = p;
      model_cnt = model_cnt + 1'b1;
      e.row  = cur_row;
      e.cnt  = model_cnt;
      e.t    = t;
      e.free = free;
      exp_q.push_back(e);
      completed++;
      cur_len = 0;
      cur_row = '0;
    end
  endtask

  task automatic cyc_drive(input bit v, input logic [PIX_W-1:0] p, input bit l, input bit a, output bit acc);
    bit free;
    @(negedge clk);
    pix_valid = v;
    pix_in    = p;
    pix_last  = l;
    row_ack   = a;
    acc  = v && pix_ready;
    free = !row_valid || a;
    @(posedge clk);
    if (acc) model_accept(p, l, free, $time);
  endtask

  // ack_mode: 0 never, 1 always, 2 only while offering the final pixel
  task automatic stream(input int start, input int n, input bit last_final, input int ack_mode);
    int i = 0;
    int budget = 0;
    bit acc;
    while (i < n && budget < 200) begin
      cyc_drive(1'b1, PIX_W'(start + i), last_final && (i == n - 1),
                (ack_mode == 1) || (ack_mode == 2 && i == n - 1), acc);
      if (acc) i++;
      budget++;
    end
    if (i < n) chk("stream_timeout", 64'(i), 64'(n));
  endtask

  task automatic idle(input int n, input bit a);
    bit acc;
    for (int k = 0; k < n; k++) cyc_drive(1'b0, '0, 1'b0, a, acc);
  endtask

  task automatic drain();
    int k = 0;
    bit acc;
    while ((exp_q.size() != 0 || err_q.size() != 0) && k < 60) begin
      cyc_drive(1'b0, '0, 1'b0, 1'b1, acc);
      k++;
    end
    cyc_drive(1'b0, '0, 1'b0, 1'b1, acc);
    chk("drain_rows_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic random_phase(input int n, input int pv, input int pa, input int pl);
    bit acc;
    for (int k = 0; k < n; k++) begin
      cyc_drive($urandom_range(0, 99) < pv, PIX_W'($urandom), $urandom_range(0, 99) < pl,
                $urandom_range(0, 99) < pa, acc);
    end
  endtask

  // Asserts reset partway through a cycle; partial rows and pending expectations are dropped
  task automatic do_reset();
    #2;
    rst       = 1'b1;
    in_reset  = 1'b1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    row_ack   = 1'b0;
    exp_q.delete();
    err_q.delete();
    cur_len   = 0;
    cur_row   = '0;
    model_cnt = '0;
    completed = 0;
    presented = 0;
    @(negedge clk);
    chk("rst_arr_out", arr_out, 64'd0);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_err", 64'(err_short_row), 64'd0);
    chk("rst_row_count", 64'(row_count), 64'd0);
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    in_reset = 1'b0;
  endtask

  // Monitor: previous-cycle view of the output interface
  logic rv_prev, ack_prev;
  row_t arr_prev;
  always @(posedge clk) begin
    rv_prev  <= row_valid;
    ack_prev <= row_ack;
    arr_prev <= arr_out;
  end

  exp_t mon_e;
  bit   new_row;
  always @(negedge clk) begin
    if (!in_reset) begin
      new_row = row_valid && (!rv_prev || ack_prev);
      if (new_row) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("row_data", arr_out, mon_e.row);
          chk("row_count", 64'(row_count), 64'(mon_e.cnt));
          if (mon_e.free) chk("row_latency", 64'($time), 64'(mon_e.t + 5));
          presented++;
        end
      end else begin
        chk("arr_out_held", arr_out, arr_prev);
        if (rv_prev && !ack_prev) chk("row_valid_held", 64'(row_valid), 64'd1);
      end
      chk("pix_ready", 64'(pix_ready), 64'(completed == presented));
      if (err_short_row) begin
        if (err_q.size() == 0) chk("err_unexpected", 64'(err_short_row), 64'd0);
        else chk("err_timing", 64'($time), 64'(err_q.pop_front() + 5));
      end else if (err_q.size() != 0 && (err_q[0] + 5) <= $time) begin
        chk("err_missing", 64'(err_short_row), 64'd1);
        void'(err_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Row 0..7 with the consumer always acking
    stream(0, 8, 1'b0, 1);
    idle(1, 1'b1);
    // Two rows with no ack: second one parks in the fill buffer
    stream(0, 16, 1'b0, 0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    // Short row padded by its last pixel
    idle(1, 1'b1);
    stream(10, 5, 1'b1, 1);
    drain();
    // Row A held, row B completes in the same cycle A is acked
    stream(40, 8, 1'b0, 0);
    idle(2, 1'b0);
    stream(50, 8, 1'b0, 2);
    idle(2, 1'b0);
    drain();
    // pix_last exactly on the SIZE-th pixel is a normal row
    stream(60, 8, 1'b1, 1);
    stream(70, 1, 1'b1, 1);
    drain();
    // Randomized traffic with varying backpressure and short-row rates
    random_phase(400, 90, 80, 5);
    random_phase(400, 70, 15, 10);
    random_phase(400, 100, 50, 30);
    drain();
    // Reset in the middle of a row, then a clean row
    stream(30, 3, 1'b0, 1);
    do_reset();
    stream(20, 8, 1'b0, 1);
    drain();
    random_phase(300, 95, 60, 8);
    drain();
    chk("err_queue_empty", 64'(err_q.size()), 64'd0);
    chk("rows_presented", 64'(presented), 64'(completed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
